// File: rtl/ex.sv
// Execute stage of the 5-stage MIPS32 pipeline.
// Logic, shift and move results are combinational. DIV/DIVU use an iterative
// radix-2 restoring divider that stalls the pipeline until {HI,LO} is ready.
// Optional feature macro: EX_DIV_EN (defined = divider built, undefined =
// DIV/DIVU behave as NOP and stallreq_o is tied low).
module ex (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        mem_whilo_i,
  input  logic [31:0] mem_hi_i,
  input  logic [31:0] mem_lo_i,
  input  logic        wb_whilo_i,
  input  logic [31:0] wb_hi_i,
  input  logic [31:0] wb_lo_i,
  input  logic        annul_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  localparam logic [7:0] EXE_AND_OP  = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP   = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b00100111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b01111100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b00000010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b00000011;
  localparam logic [7:0] EXE_MOVZ_OP = 8'b00001010;
  localparam logic [7:0] EXE_MOVN_OP = 8'b00001011;
  localparam logic [7:0] EXE_MFHI_OP = 8'b00010000;
  localparam logic [7:0] EXE_MTHI_OP = 8'b00010001;
  localparam logic [7:0] EXE_MFLO_OP = 8'b00010010;
  localparam logic [7:0] EXE_MTLO_OP = 8'b00010011;
`ifdef EX_DIV_EN
  localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;
`endif

  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE  = 3'b011;

  logic [31:0] cur_hi, cur_lo;
  logic [31:0] logic_res, shift_res, move_res;
  logic        div_stall, div_done;
  logic [31:0] div_hi, div_lo;

  // Newest HI/LO value: MEM stage write beats WB stage write beats the file.
  always_comb begin
    cur_hi = hi_i;
    cur_lo = lo_i;
    if (mem_whilo_i) begin
      cur_hi = mem_hi_i;
      cur_lo = mem_lo_i;
    end else if (wb_whilo_i) begin
      cur_hi = wb_hi_i;
      cur_lo = wb_lo_i;
    end
  end

  // Bitwise logic results.
  always_comb begin
    logic_res = 32'h0;
    case (aluop_i)
      EXE_AND_OP: logic_res = reg1_i & reg2_i;
      EXE_OR_OP:  logic_res = reg1_i | reg2_i;
      EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
      default:    logic_res = 32'h0;
    endcase
  end

  // Shifts: reg2 is the operand, low five bits of reg1 the amount.
  always_comb begin
    shift_res = 32'h0;
    case (aluop_i)
      EXE_SLL_OP: shift_res = reg2_i << reg1_i[4:0];
      EXE_SRL_OP: shift_res = reg2_i >> reg1_i[4:0];
      EXE_SRA_OP: shift_res = 32'($signed(reg2_i) >>> reg1_i[4:0]);
      default:    shift_res = 32'h0;
    endcase
  end

  // GPR-destined move results; the MOVZ/MOVN condition was resolved in ID.
  always_comb begin
    move_res = 32'h0;
    case (aluop_i)
      EXE_MOVZ_OP, EXE_MOVN_OP: move_res = reg1_i;
      EXE_MFHI_OP:              move_res = cur_hi;
      EXE_MFLO_OP:              move_res = cur_lo;
      default:                  move_res = 32'h0;
    endcase
  end

`ifdef EX_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_e;

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;   // dividend shifts out as quotient shifts in
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;   // divisor magnitude
  logic        negq_q, negq_d; // negate quotient at the end
  logic        negr_q, negr_d; // negate remainder at the end
  logic        is_div, is_sdiv;
  logic [32:0] trial;
  logic        fits;

  assign is_div  = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
  assign is_sdiv = (aluop_i == EXE_DIV_OP);
  // Partial remainder can reach 33 bits when the divisor exceeds 2^31.
  assign trial   = {rem_q, quo_q[31]};
  assign fits    = (trial >= {1'b0, dvs_q});

  // Divider state registers, cleared synchronously.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      quo_q   <= 32'h0;
      rem_q   <= 32'h0;
      dvs_q   <= 32'h0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  // Divider next state: launch in IDLE, one restoring step per BUSY cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    div_stall = 1'b0;
    div_done  = 1'b0;
    if (annul_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_div) begin
            div_stall = 1'b1;
            if (reg2_i == 32'h0) begin
              state_d = S_DONE;
              quo_d   = 32'h0;
              rem_d   = 32'h0;
              negq_d  = 1'b0;
              negr_d  = 1'b0;
            end else begin
              state_d = S_BUSY;
              cnt_d   = 5'd0;
              rem_d   = 32'h0;
              quo_d   = (is_sdiv && reg1_i[31]) ? -reg1_i : reg1_i;
              dvs_d   = (is_sdiv && reg2_i[31]) ? -reg2_i : reg2_i;
              negq_d  = is_sdiv && (reg1_i[31] ^ reg2_i[31]);
              negr_d  = is_sdiv && reg1_i[31];
            end
          end
        end
        S_BUSY: begin
          div_stall = 1'b1;
          // True difference is below 2^32, so the 32-bit wrap is exact.
          rem_d = fits ? (trial[31:0] - dvs_q) : trial[31:0];
          quo_d = {quo_q[30:0], fits};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = S_DONE;
        end
        S_DONE: begin
          div_done = 1'b1;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign div_lo = negq_q ? -quo_q : quo_q;
  assign div_hi = negr_q ? -rem_q : rem_q;
`else
  logic unused_clk;
  assign unused_clk = clk;
  assign div_stall  = 1'b0;
  assign div_done   = 1'b0;
  assign div_lo     = 32'h0;
  assign div_hi     = 32'h0;
`endif

  // Output bundle; everything is forced to zero while reset is held.
  always_comb begin
    wd_o       = 5'd0;
    wreg_o     = 1'b0;
    wdata_o    = 32'h0;
    whilo_o    = 1'b0;
    hi_o       = 32'h0;
    lo_o       = 32'h0;
    stallreq_o = 1'b0;
    if (!rst) begin
      wd_o   = wd_i;
      wreg_o = wreg_i & ~annul_i;
      case (alusel_i)
        EXE_RES_LOGIC: wdata_o = logic_res;
        EXE_RES_SHIFT: wdata_o = shift_res;
        EXE_RES_MOVE:  wdata_o = move_res;
        default:       wdata_o = 32'h0;
      endcase
      if (div_done) begin
        whilo_o = 1'b1;
        hi_o    = div_hi;
        lo_o    = div_lo;
      end else if (aluop_i == EXE_MTHI_OP) begin
        whilo_o = 1'b1;
        hi_o    = reg1_i;
        lo_o    = cur_lo;
      end else if (aluop_i == EXE_MTLO_OP) begin
        whilo_o = 1'b1;
        hi_o    = cur_hi;
        lo_o    = reg1_i;
      end
      if (annul_i) whilo_o = 1'b0;
      stallreq_o = div_stall;
    end
  end

endmodule

// File: tb/tb_ex.sv
// Self-checking bench for the EX stage: directed vector table, randomized
// combinational ops against a reference model, and divide sequences.
module tb_ex;

  localparam logic [7:0] OP_NOP  = 8'b00000000;
  localparam logic [7:0] OP_AND  = 8'b00100100;
  localparam logic [7:0] OP_OR   = 8'b00100101;
  localparam logic [7:0] OP_XOR  = 8'b00100110;
  localparam logic [7:0] OP_NOR  = 8'b00100111;
  localparam logic [7:0] OP_SLL  = 8'b01111100;
  localparam logic [7:0] OP_SRL  = 8'b00000010;
  localparam logic [7:0] OP_SRA  = 8'b00000011;
  localparam logic [7:0] OP_MOVZ = 8'b00001010;
  localparam logic [7:0] OP_MOVN = 8'b00001011;
  localparam logic [7:0] OP_MFHI = 8'b00010000;
  localparam logic [7:0] OP_MTHI = 8'b00010001;
  localparam logic [7:0] OP_MFLO = 8'b00010010;
  localparam logic [7:0] OP_MTLO = 8'b00010011;
  localparam logic [7:0] OP_DIV  = 8'b00011010;
  localparam logic [7:0] OP_DIVU = 8'b00011011;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MOVE  = 3'b011;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop;
  logic [2:0]  alusel;
  logic [31:0] reg1, reg2, hi, lo, mem_hi, mem_lo, wb_hi, wb_lo;
  logic [4:0]  wd;
  logic        wreg, mem_whilo, wb_whilo, annul;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o, stallreq_o;
  logic [31:0] wdata_o, hi_o, lo_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex dut (
    .clk(clk), .rst(rst), .aluop_i(aluop), .alusel_i(alusel),
    .reg1_i(reg1), .reg2_i(reg2), .wd_i(wd), .wreg_i(wreg),
    .hi_i(hi), .lo_i(lo),
    .mem_whilo_i(mem_whilo), .mem_hi_i(mem_hi), .mem_lo_i(mem_lo),
    .wb_whilo_i(wb_whilo), .wb_hi_i(wb_hi), .wb_lo_i(wb_lo),
    .annul_i(annul),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
    .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
  );

  typedef struct {
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] r1, r2, h, l;
    logic        mw;
    logic [31:0] mh, ml;
    logic        ww;
    logic [31:0] wh, wl;
    logic        an, wr;
    logic [31:0] e_wdata;
    logic        e_whilo;
    logic [31:0] e_hi, e_lo;
    logic        e_wreg;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference for non-divide ops, from the instruction definitions.
  function automatic void comb_model(
    input  logic [7:0]  op, input logic [2:0] sel,
    input  logic [31:0] r1, r2, h, l,
    input  logic mw, input logic [31:0] mh, ml,
    input  logic ww, input logic [31:0] wh, wl,
    output logic [31:0] e_wdata, output logic e_whilo,
    output logic [31:0] e_hi, e_lo);
    logic [31:0] nh, nl, pw;
    int s;
    nh = mw ? mh : (ww ? wh : h);
    nl = mw ? ml : (ww ? wl : l);
    s  = int'(r1 % 32);
    pw = 32'd1;
    for (int i = 0; i < s; i++) pw = pw * 2;
    e_wdata = 32'h0; e_whilo = 1'b0; e_hi = 32'h0; e_lo = 32'h0;
    if (sel == SEL_LOGIC) begin
      if (op == OP_AND) e_wdata = r1 & r2;
      if (op == OP_OR)  e_wdata = r1 | r2;
      if (op == OP_XOR) e_wdata = r1 ^ r2;
      if (op == OP_NOR) e_wdata = ~(r1 | r2);
    end else if (sel == SEL_SHIFT) begin
      if (op == OP_SLL) e_wdata = r2 * pw;
      if (op == OP_SRL) e_wdata = r2 / pw;
      if (op == OP_SRA) e_wdata = r2[31] ? ~((~r2) / pw) : r2 / pw;
    end else if (sel == SEL_MOVE) begin
      if (op == OP_MOVZ || op == OP_MOVN) e_wdata = r1;
      if (op == OP_MFHI) e_wdata = nh;
      if (op == OP_MFLO) e_wdata = nl;
    end
    if (op == OP_MTHI) begin e_whilo = 1'b1; e_hi = r1; e_lo = nl; end
    if (op == OP_MTLO) begin e_whilo = 1'b1; e_hi = nh; e_lo = r1; end
  endfunction

  // Reference divide: truncating division, remainder takes dividend sign.
  function automatic void div_model(input logic sgn, input logic [31:0] a, b,
                                    output logic [31:0] q, r);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 32'h0) begin
      q = 32'h0; r = 32'h0;
    end else if (!sgn) begin
      q = a / b; r = a % b;
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      q = 32'h80000000; r = 32'h0;
    end else begin
      q = 32'(sa / sb); r = 32'(sa % sb);
    end
  endfunction

  task automatic apply(input vec_t v);
    aluop = v.op; alusel = v.sel; reg1 = v.r1; reg2 = v.r2; hi = v.h; lo = v.l;
    mem_whilo = v.mw; mem_hi = v.mh; mem_lo = v.ml;
    wb_whilo = v.ww; wb_hi = v.wh; wb_lo = v.wl; annul = v.an; wreg = v.wr;
  endtask

  task automatic check_vec(input string nm, input vec_t v);
    chk({nm, ".wdata"}, wdata_o, v.e_wdata);
    chk({nm, ".whilo"}, 32'(whilo_o), 32'(v.e_whilo));
    chk({nm, ".wreg"}, 32'(wreg_o), 32'(v.e_wreg));
    chk({nm, ".wd"}, 32'(wd_o), 32'(wd));
    chk({nm, ".stall"}, 32'(stallreq_o), 32'h0);
    if (v.e_whilo) begin
      chk({nm, ".hi"}, hi_o, v.e_hi);
      chk({nm, ".lo"}, lo_o, v.e_lo);
    end
  endtask

`ifdef EX_DIV_EN
  task automatic do_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eq, er;
    int n, need;
    div_model(op == OP_DIV, a, b, eq, er);
    need = (b == 32'h0) ? 1 : 33;
    @(negedge clk);
    aluop = op; alusel = SEL_NOP; reg1 = a; reg2 = b;
    annul = 1'b0; mem_whilo = 1'b0; wb_whilo = 1'b0;
    #1;
    n = 0;
    while (stallreq_o === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      reg1 = $urandom; reg2 = $urandom;  // latched operands must be used
      #1;
    end
    chk("div_stall_cycles", 32'(n), 32'(need));
    chk("div_whilo", 32'(whilo_o), 32'h1);
    chk("div_lo", lo_o, eq);
    chk("div_hi", hi_o, er);
    @(negedge clk);
    aluop = OP_NOP;
    #1;
    chk("div_after_stall", 32'(stallreq_o), 32'h0);
    chk("div_after_whilo", 32'(whilo_o), 32'h0);
  endtask
`endif

  vec_t vt[12];

  initial begin
    vt[0]  = '{OP_OR,   SEL_LOGIC, 32'h0000F0F0, 32'h00FF0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
               32'h00FFF0F0, 0, 0, 0, 1};
    vt[1]  = '{OP_SRA,  SEL_SHIFT, 32'd4, 32'h80000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
               32'hF8000000, 0, 0, 0, 1};
    vt[2]  = '{OP_MFHI, SEL_MOVE, 0, 0, 32'd1, 0, 1, 32'd3, 0, 1, 32'd2, 0, 0, 1,
               32'd3, 0, 0, 0, 1};
    vt[3]  = '{OP_MFHI, SEL_MOVE, 0, 0, 32'd1, 0, 0, 32'd3, 0, 1, 32'd2, 0, 0, 1,
               32'd2, 0, 0, 0, 1};
    vt[4]  = '{OP_MFLO, SEL_MOVE, 0, 0, 0, 32'd11, 0, 0, 32'd33, 0, 0, 32'd22, 0, 1,
               32'd11, 0, 0, 0, 1};
    vt[5]  = '{OP_MTHI, SEL_MOVE, 32'hDEADBEEF, 0, 0, 32'd5, 0, 0, 0, 1, 0, 32'd6, 0, 1,
               32'h0, 1, 32'hDEADBEEF, 32'd6, 1};
    vt[6]  = '{OP_MTLO, SEL_MOVE, 32'hCAFEF00D, 0, 32'd7, 0, 0, 0, 0, 0, 0, 0, 0, 1,
               32'h0, 1, 32'd7, 32'hCAFEF00D, 1};
    vt[7]  = '{OP_MTHI, SEL_MOVE, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,
               32'h0, 0, 0, 0, 0};
    vt[8]  = '{OP_SLL,  SEL_SHIFT, 32'd33, 32'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
               32'd2, 0, 0, 0, 1};
    vt[9]  = '{OP_NOR,  SEL_LOGIC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
               32'hFFFFFFFF, 0, 0, 0, 1};
    vt[10] = '{OP_OR,   SEL_NOP, 32'hFFFF0000, 32'h0000FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
               32'h0, 0, 0, 0, 1};
    vt[11] = '{OP_MOVZ, SEL_MOVE, 32'h00001234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
               32'h00001234, 0, 0, 0, 0};

    // Reset: every output low regardless of inputs.
    rst = 1'b1; apply(vt[0]); wd = 5'd10;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.wd", 32'(wd_o), 32'h0);
    chk("rst.wreg", 32'(wreg_o), 32'h0);
    chk("rst.wdata", wdata_o, 32'h0);
    chk("rst.whilo", 32'(whilo_o), 32'h0);
    chk("rst.hi", hi_o, 32'h0);
    chk("rst.lo", lo_o, 32'h0);
    chk("rst.stall", 32'(stallreq_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      wd = 5'(i + 3);
      apply(vt[i]);
      #1;
      check_vec($sformatf("vec%0d", i), vt[i]);
    end

    // Randomized non-divide ops.
    for (int i = 0; i < 60; i++) begin
      vec_t v;
      logic [7:0] ops[13];
      int k;
      ops = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA,
              OP_MOVZ, OP_MOVN, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO};
      k = $urandom_range(0, 12);
      v.op  = ops[k];
      v.sel = (k < 4) ? SEL_LOGIC : ((k < 7) ? SEL_SHIFT : SEL_MOVE);
      v.r1 = $urandom; v.r2 = $urandom; v.h = $urandom; v.l = $urandom;
      v.mw = 1'($urandom); v.mh = $urandom; v.ml = $urandom;
      v.ww = 1'($urandom); v.wh = $urandom; v.wl = $urandom;
      v.an = ($urandom_range(0, 7) == 0);
      v.wr = 1'($urandom);
      comb_model(v.op, v.sel, v.r1, v.r2, v.h, v.l, v.mw, v.mh, v.ml,
                 v.ww, v.wh, v.wl, v.e_wdata, v.e_whilo, v.e_hi, v.e_lo);
      if (v.an) v.e_whilo = 1'b0;
      v.e_wreg = v.wr & ~v.an;
      @(negedge clk);
      wd = 5'($urandom);
      apply(v);
      #1;
      check_vec($sformatf("rnd%0d", i), v);
    end

    @(negedge clk);
    apply(vt[10]); aluop = OP_NOP; wreg = 1'b1;

`ifdef EX_DIV_EN
    do_div(OP_DIV,  32'hFFFFFFF9, 32'd2);
    do_div(OP_DIVU, 32'hFFFFFFF9, 32'd2);
    do_div(OP_DIVU, 32'd1234, 32'd0);
    do_div(OP_DIV,  32'd99, 32'd0);
    do_div(OP_DIV,  32'h80000000, 32'hFFFFFFFF);
    do_div(OP_DIVU, 32'hFFFFFFFF, 32'h80000001);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i == 5) ? 32'h0 : ($urandom >> $urandom_range(0, 28));
      do_div((i % 2 == 0) ? OP_DIV : OP_DIVU, a, b);
    end

    // Reset in the middle of a divide.
    @(negedge clk);
    aluop = OP_DIV; alusel = SEL_NOP; reg1 = 32'd100; reg2 = 32'd7; annul = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst.stall", 32'(stallreq_o), 32'h0);
    chk("midrst.whilo", 32'(whilo_o), 32'h0);
    chk("midrst.wreg", 32'(wreg_o), 32'h0);
    chk("midrst.wd", 32'(wd_o), 32'h0);
    chk("midrst.hilo", hi_o | lo_o | wdata_o, 32'h0);
    @(negedge clk);
    rst = 1'b0; aluop = OP_NOP;
    #1;
    chk("midrst.idle_stall", 32'(stallreq_o), 32'h0);
    chk("midrst.idle_whilo", 32'(whilo_o), 32'h0);
    do_div(OP_DIV, 32'hFFFFFF9C, 32'd7);

    // Annul in the middle of a divide: never a HI/LO write afterwards.
    @(negedge clk);
    aluop = OP_DIV; alusel = SEL_NOP; reg1 = 32'd100; reg2 = 32'd7; annul = 1'b0;
    repeat (11) @(negedge clk);
    annul = 1'b1;
    #1;
    chk("annul.stall", 32'(stallreq_o), 32'h0);
    chk("annul.whilo", 32'(whilo_o), 32'h0);
    chk("annul.wreg", 32'(wreg_o), 32'h0);
    @(negedge clk);
    annul = 1'b0; aluop = OP_NOP;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 40; c++) begin
        #1;
        if (whilo_o !== 1'b0 || stallreq_o !== 1'b0) seen++;
        @(negedge clk);
      end
      chk("annul.quiet_after", 32'(seen), 32'h0);
    end
    do_div(OP_DIVU, 32'd1000, 32'd33);
`else
    // Divider not built: DIV behaves as a NOP, no stall, no HI/LO write.
    @(negedge clk);
    aluop = OP_DIV; alusel = SEL_NOP; reg1 = 32'd10; reg2 = 32'd3; annul = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("nodiv.stall%0d", c), 32'(stallreq_o), 32'h0);
      chk($sformatf("nodiv.whilo%0d", c), 32'(whilo_o), 32'h0);
      chk($sformatf("nodiv.wdata%0d", c), wdata_o, 32'h0);
      @(negedge clk);
    end
    aluop = OP_DIVU; reg2 = 32'd0;
    #1;
    chk("nodiv.divu_stall", 32'(stallreq_o), 32'h0);
    chk("nodiv.divu_whilo", 32'(whilo_o), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
